// File: rtl/frac_expand.sv
// Checks a two-digit fraction is reduced, then steps its expansion by k every NUM clocks.
// Optional build macro FRAC_EXPAND_AUTO_RETURN_EN: return to SETUP on multiplier overflow.
module frac_expand #(
    parameter int NUM = 50_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       select,
    input  logic       add,
    input  logic       next,
    input  logic [3:0] data_in,
    output logic [3:0] data_out
);

    localparam logic [1:0] SETUP  = 2'b00;
    localparam logic [1:0] CHECK  = 2'b01;
    localparam logic [1:0] EXPAND = 2'b10;

    localparam logic [31:0] TMAX = 32'(NUM - 1);

    logic [1:0]  state;
    logic [3:0]  data [0:1];
    logic [3:0]  k;
    logic [31:0] timer;
    logic        add_q, next_q;
    logic        add_red, next_red;

    logic [4:0]  sum;
    logic [3:0]  add_val;
    logic [3:0]  cur;
    logic [3:0]  prod;
    logic [3:0]  k_inc;
    logic [7:0]  p0, p1;
    logic        fits;
    logic        tick;
    logic        reduced;

    // Digits never exceed 9, so the primes 2,3,5,7 cover every common factor.
    function automatic logic coprime(input logic [3:0] a, input logic [3:0] b);
        if (a == 4'd0) return b == 4'd1;
        if (b == 4'd0) return a == 4'd1;
        return !((a % 4'd2 == 4'd0 && b % 4'd2 == 4'd0) ||
                 (a % 4'd3 == 4'd0 && b % 4'd3 == 4'd0) ||
                 (a % 4'd5 == 4'd0 && b % 4'd5 == 4'd0) ||
                 (a % 4'd7 == 4'd0 && b % 4'd7 == 4'd0));
    endfunction

    assign add_red  = add & ~add_q;
    assign next_red = next & ~next_q;

    always_comb begin
        cur = data[select];
        sum = {1'b0, cur} + {1'b0, data_in};
        if (sum >= 5'd20)
            add_val = 4'(sum - 5'd20);
        else if (sum >= 5'd10)
            add_val = 4'(sum - 5'd10);
        else
            add_val = sum[3:0];
        prod    = cur * k;
        k_inc   = k + 4'd1;
        p0      = {4'd0, data[0]} * {4'd0, k_inc};
        p1      = {4'd0, data[1]} * {4'd0, k_inc};
        fits    = (p0 <= 8'd9) && (p1 <= 8'd9);
        tick    = (timer == TMAX);
        reduced = coprime(data[0], data[1]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= SETUP;
            data[0]  <= 4'd0;
            data[1]  <= 4'd0;
            data_out <= 4'd0;
            k        <= 4'd1;
            timer    <= 32'd0;
            add_q    <= 1'b0;
            next_q   <= 1'b0;
        end else begin
            add_q  <= add;
            next_q <= next;
            case (state)
                SETUP: begin
                    if (add_red) begin
                        data[select] <= add_val;
                        data_out     <= add_val;
                    end else begin
                        data_out <= cur;
                    end
                    if (next_red)
                        state <= CHECK;
                end
                CHECK: begin
                    if (reduced) begin
                        k        <= 4'd1;
                        timer    <= 32'd0;
                        state    <= EXPAND;
                        data_out <= cur;
                    end else if (next_red) begin
                        state    <= SETUP;
                        data_out <= cur;
                    end else begin
                        data_out <= 4'hE;
                    end
                end
                EXPAND: begin
                    if (next_red) begin
                        state    <= SETUP;
                        k        <= 4'd1;
                        timer    <= 32'd0;
                        data_out <= cur;
                    end else begin
                        data_out <= prod;
                        if (tick) begin
                            timer <= 32'd0;
                            if (fits) begin
                                k <= k_inc;
                            end else begin
`ifdef FRAC_EXPAND_AUTO_RETURN_EN
                                state    <= SETUP;
                                k        <= 4'd1;
                                data_out <= cur;
`endif
                            end
                        end else begin
                            timer <= timer + 32'd1;
                        end
                    end
                end
                default: begin
                    state    <= SETUP;
                    k        <= 4'd1;
                    timer    <= 32'd0;
                    data_out <= cur;
                end
            endcase
        end
    end

endmodule
